// File: rtl/q16_pkg.sv
// Shared Q16.16 fixed-point types and constants for the multiplier/accumulator datapath.
package q16_pkg;

  typedef logic signed [31:0] q16_t;

  localparam q16_t Q16_MAX = 32'sh7FFF_FFFF;
  localparam q16_t Q16_MIN = 32'sh8000_0000;
  localparam q16_t Q16_ONE = 32'sh0001_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accum_state_t;

endpackage

// File: rtl/q16_sat.sv
// Combinational clamp of a wide signed value into Q16.16, with a clip flag.
module q16_sat
  import q16_pkg::*;
#(
  parameter int IN_W = 40
) (
  input  logic signed [IN_W-1:0] in_val,
  output q16_t                   out_val,
  output logic                   clip
);

  // The value fits in 32 bits exactly when all bits from 31 upward agree with the sign.
  logic fits;
  assign fits = (&in_val[IN_W-1:31]) | ~(|in_val[IN_W-1:31]);

  always_comb begin
    out_val = in_val[31:0];
    clip    = 1'b0;
    if (!fits) begin
      clip    = 1'b1;
      out_val = in_val[IN_W-1] ? Q16_MIN : Q16_MAX;
    end
  end

endmodule

// File: rtl/q16_dot_accum.sv
// Streaming Q16.16 window accumulator: sums N_TERMS products, emits a saturated sum, then clears.
module q16_dot_accum
  import q16_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int ACC_W   = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_prod,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_sum,
  output logic         out_sat,
  output logic [7:0]   term_cnt,
  output accum_state_t dbg_state
);

  // Handshake: a product transfers on a rising edge where in_valid & in_ready;
  // a sum transfers on a rising edge where out_valid & out_ready. Both ready/valid
  // outputs depend on state only, and flush overrides any transfer that cycle.

  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  accum_state_t             state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [7:0]               cnt_q;
  q16_t                     sum_q;
  logic                     sat_q;
  q16_t                     sat_val;
  logic                     sat_clip;

  assign acc_d = acc_q + {{(ACC_W-32){in_prod[31]}}, in_prod};

  q16_sat #(.IN_W(ACC_W)) u_sat (
    .in_val  (acc_d),
    .out_val (sat_val),
    .clip    (sat_clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == LAST_IDX) begin
              sum_q   <= sat_val;
              sat_q   <= sat_clip;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_sat   = sat_q;
  assign term_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/q16_dot_accum.md
# q16_dot_accum

Streaming Q16.16 dot-product accumulator that sits directly downstream of the fixed-point multiplier. It consumes one signed Q16.16 product per handshake and sums a fixed number of terms (a kernel window) in a wide guarded accumulator. It emits one saturated Q16.16 sum per window with valid/ready backpressure, then clears for the next window.

## Interface
Parameters:
- N_TERMS, 9: products per window; legal range 2..256.
- ACC_W, 40: accumulator width in bits; must satisfy ACC_W ≥ 32 + ceil(log2(N_TERMS)).

Ports:
- clk  in  1  sole clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  32  signed Q16.16 product from the multiplier's 32-bit result.
- flush  in  1  synchronous abort of the current window.
- out_valid  out  1  out_sum holds a completed window sum.
- out_ready  in  1  consumer accepts out_sum.
- out_sum  out  32  signed Q16.16 window sum, saturated.
- out_sat  out  1  out_sum was clipped to a saturation bound.
- term_cnt  out  8  number of terms accepted in the current window.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - On accept (in_valid & in_ready): acc ← acc + sign-extend(in_prod) to ACC_W, and term_cnt++.
  - On the accept where term_cnt == N_TERMS-1: register the saturated sum of acc+in_prod into out_sum and out_sat, clear acc and term_cnt, and go to HOLD.
- HOLD:
  - in_ready=0, out_valid=1, and out_sum/out_sat are held stable.
  - On out_ready=1: go to ACCUM.
- Arithmetic:
  - Addition is full-precision two's complement at ACC_W bits, so no internal overflow can occur for legal parameters.
  - Saturation bounds are Q16_MAX=0x7FFF_FFFF and Q16_MIN=0x8000_0000.
  - If the final sum exceeds Q16_MAX, output Q16_MAX with out_sat=1. If it is below Q16_MIN, output Q16_MIN with out_sat=1. Otherwise output the sum truncated to 32 bits with out_sat=0.
- flush:
  - In any state, clears acc and term_cnt, forces out_valid=0, and goes to ACCUM next cycle.
  - flush wins over a simultaneous input accept (the product is dropped) and over a simultaneous out_ready.
- Simultaneous in_valid and out_ready in HOLD: no input is accepted that cycle, because in_ready=0.
- Reset: all registers clear immediately.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_sat=0, term_cnt=0.
  - A window in progress is discarded.

## Timing
- Latency: the last term is accepted at edge t; out_valid=1 from edge t until the cycle out_ready is seen high. The earliest return to ACCUM is edge t+1.
- Throughput: one window per N_TERMS+1 cycles at best, since HOLD lasts at least one cycle.
- in_ready is a pure function of state (no combinational path from out_ready), so the block can be chained with a registered multiplier.
- out_sum and out_sat are registered outputs and carry no combinational path from inputs.
- in_prod is sampled only on accept; its value is don't-care otherwise.

## Structure
- Shared package q16_pkg, holding:
  - typedef q16_t (logic signed [31:0])
  - constants Q16_MAX, Q16_MIN, Q16_ONE=0x0001_0000
  - enum accum_state_t {ACCUM, HOLD}
- The multiplier side reuses q16_t from the same package.
- One sub-module, q16_sat: combinational clamp from ACC_W signed to q16_t plus a clip flag. It is parameterized by IN_W and is reusable by other Q16.16 stages.
- The top level contains the FSM, counter, accumulator and output registers.

## Test plan
- Nine accepts of 0x0001_0000 (1.0) with out_ready=1 → one cycle after the 9th accept: out_valid=1, out_sum=0x0009_0000, out_sat=0, term_cnt=0.
- Nine accepts of 0x7FFF_FFFF → out_sum=0x7FFF_FFFF, out_sat=1. Nine accepts of 0x8000_0000 → out_sum=0x8000_0000, out_sat=1.
- Mixed window: four terms of 0x0001_8000 (1.5) and five terms of 0xFFFF_0000 (-1.0) → out_sum=0x0001_0000, out_sat=0. Also verify that accumulating past +32768 mid-window and then returning in range does not set out_sat.
- Backpressure: complete a window and hold out_ready=0 for 5 cycles while in_valid=1 → out_sum stable, in_ready=0, no terms counted. Then raise out_ready → ACCUM next cycle, and the next window of nine 1.0 terms gives 0x0009_0000.
- flush after 4 accepts, asserted together with an in_valid → term_cnt=0 and that product dropped. A following nine 1.0 terms gives 0x0009_0000. flush in HOLD → out_valid falls next cycle.
- Assert rst asynchronously mid-cycle after 6 accepts → outputs go to reset values immediately without a clock edge. After release, nine 1.0 terms gives 0x0009_0000.
